// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with queued multdiv
// results onto one registered register-file write port. The ALU normally
// wins. A waiting multdiv result is forced through after STARVE_LIMIT
// consecutive losses, and the ALU is stalled for that cycle.
module writeback_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        md_valid,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [1:0]  md_count
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  // Two-entry FIFO. Slot 0 is always the head; a pop shifts slot 1 down.
  logic [4:0]    q_reg   [2];
  logic [31:0]   q_data  [2];
  logic [1:0]    count;
  logic [SW-1:0] starve_cnt;

  logic [4:0]    q_reg_n  [2];
  logic [31:0]   q_data_n [2];
  logic [1:0]    count_n;
  logic [1:0]    count_after_pop;
  logic [SW-1:0] starve_cnt_n;

  logic alu_req;
  logic fifo_nonempty;
  logic force_md;
  logic grant_alu;
  logic pop;
  logic push;

  // Grant decision, handshake and FIFO next state.
  always_comb begin
    alu_req       = alu_valid && (alu_reg != '0);
    fifo_nonempty = (count != 2'd0);
    force_md      = fifo_nonempty && (starve_cnt == LIMIT);
    md_ready      = (count < 2'd2);
    alu_stall     = force_md && alu_req;
    grant_alu     = alu_req && !force_md;
    pop           = fifo_nonempty && (force_md || !alu_req);
    // md_reg = 0 completes the handshake but the result is dropped.
    push          = md_valid && md_ready && (md_reg != '0);

    q_reg_n  = q_reg;
    q_data_n = q_data;
    if (pop) begin
      q_reg_n[0]  = q_reg[1];
      q_data_n[0] = q_data[1];
    end
    count_after_pop = count - 2'(pop);
    // New entry lands behind whatever survives the pop, preserving FIFO order.
    if (push) begin
      if (count_after_pop == 2'd0) begin
        q_reg_n[0]  = md_reg;
        q_data_n[0] = md_data;
      end else begin
        q_reg_n[1]  = md_reg;
        q_data_n[1] = md_data;
      end
    end
    count_n = count_after_pop + 2'(push);

    starve_cnt_n = starve_cnt;
    if (pop || !fifo_nonempty) begin
      starve_cnt_n = '0;
    end else if (grant_alu && (starve_cnt != LIMIT)) begin
      starve_cnt_n = starve_cnt + 1'b1;
    end
  end

  // FIFO storage, occupancy and starvation counter.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      count      <= '0;
      starve_cnt <= '0;
      q_reg[0]   <= '0;
      q_reg[1]   <= '0;
      q_data[0]  <= '0;
      q_data[1]  <= '0;
    end else begin
      count      <= count_n;
      starve_cnt <= starve_cnt_n;
      q_reg      <= q_reg_n;
      q_data     <= q_data_n;
    end
  end

  // Registered write port; index and data hold when nothing is granted.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else if (grant_alu) begin
      ctrl_writeEnable <= 1'b1;
      ctrl_writeReg    <= alu_reg;
      data_writeReg    <= alu_data;
    end else if (pop) begin
      ctrl_writeEnable <= 1'b1;
      ctrl_writeReg    <= q_reg[0];
      data_writeReg    <= q_data[0];
    end else begin
      ctrl_writeEnable <= 1'b0;
    end
  end

  assign md_count = count;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter: directed vector table, a short
// push/pop ordering sequence, then randomized traffic against a queue model.
module tb_writeback_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [1:0]  md_count;

  writeback_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock),
    .ctrl_reset(ctrl_reset),
    .alu_valid(alu_valid),
    .alu_reg(alu_reg),
    .alu_data(alu_data),
    .alu_stall(alu_stall),
    .md_valid(md_valid),
    .md_reg(md_reg),
    .md_data(md_data),
    .md_ready(md_ready),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .md_count(md_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic rst, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    ctrl_reset = rst; alu_valid = av; alu_reg = ar; alu_data = ad;
    md_valid = mv; md_reg = mr; md_data = md;
  endtask

  task automatic chk_outs(input string tag, input logic st, input logic rdy, input logic [1:0] cnt,
                          input logic we, input logic [4:0] wr, input logic [31:0] wd);
    chk({tag, ".alu_stall"}, 32'(alu_stall), 32'(st));
    chk({tag, ".md_ready"}, 32'(md_ready), 32'(rdy));
    chk({tag, ".md_count"}, 32'(md_count), 32'(cnt));
    chk({tag, ".we"}, 32'(ctrl_writeEnable), 32'(we));
    chk({tag, ".wreg"}, 32'(ctrl_writeReg), 32'(wr));
    chk({tag, ".wdata"}, data_writeReg, wd);
  endtask

  // Directed vectors: inputs applied for one cycle, outputs sampled mid-cycle.
  typedef struct {
    logic rst; logic av; logic [4:0] ar; logic [31:0] ad;
    logic mv; logic [4:0] mr; logic [31:0] md;
    logic st; logic rdy; logic [1:0] cnt; logic we; logic [4:0] wr; logic [31:0] wd;
  } vec_t;

  function automatic vec_t mk(logic rst, logic av, logic [4:0] ar, logic [31:0] ad,
                              logic mv, logic [4:0] mr, logic [31:0] md,
                              logic st, logic rdy, logic [1:0] cnt, logic we, logic [4:0] wr, logic [31:0] wd);
    vec_t v;
    v.rst = rst; v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md;
    v.st = st; v.rdy = rdy; v.cnt = cnt; v.we = we; v.wr = wr; v.wd = wd;
    return v;
  endfunction

  localparam logic [31:0] DB = 32'hDEADBEEF;
  vec_t vecs[30];

  // Reference model: queue of pending multdiv results plus a loss counter.
  typedef struct packed { logic [4:0] r; logic [31:0] d; } ent_t;
  ent_t        m_q[$];
  int unsigned m_starve;
  logic        m_we;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;

  function automatic logic m_stall();
    return (m_q.size() != 0) && (m_starve == LIMIT) && alu_valid && (alu_reg != 5'd0);
  endfunction

  task automatic model_step();
    bit   alu_req   = alu_valid && (alu_reg != 5'd0);
    bit   was_empty = (m_q.size() == 0);
    bit   accept    = md_valid && (m_q.size() < 2) && (md_reg != 5'd0);
    bit   popped    = 0;
    ent_t h;
    if (ctrl_reset) begin
      m_q.delete(); m_starve = 0; m_we = 0; m_wreg = '0; m_wdata = '0;
      return;
    end
    if (!was_empty && (m_starve == LIMIT || !alu_req)) begin
      h = m_q.pop_front(); popped = 1;
      m_we = 1; m_wreg = h.r; m_wdata = h.d;
    end else if (alu_req) begin
      m_we = 1; m_wreg = alu_reg; m_wdata = alu_data;
    end else begin
      m_we = 0;
    end
    if (accept) m_q.push_back({md_reg, md_data});
    if (popped || was_empty) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
  endtask

  initial begin
    vecs[0]  = mk(1,0,0,0,0,0,0,            0,1,0,0,0,0);
    vecs[1]  = mk(0,1,5,32'h1234,0,0,0,     0,1,0,0,0,0);
    vecs[2]  = mk(0,0,0,0,0,0,0,            0,1,0,1,5,32'h1234);
    vecs[3]  = mk(0,0,0,0,0,0,0,            0,1,0,0,5,32'h1234);
    vecs[4]  = mk(0,0,0,0,1,7,DB,           0,1,0,0,5,32'h1234);
    vecs[5]  = mk(0,0,0,0,0,0,0,            0,1,1,0,5,32'h1234);
    vecs[6]  = mk(0,0,0,0,0,0,0,            0,1,0,1,7,DB);
    vecs[7]  = mk(0,1,0,32'h55,1,0,32'h66,  0,1,0,0,7,DB);
    vecs[8]  = mk(0,0,0,0,0,0,0,            0,1,0,0,7,DB);
    vecs[9]  = mk(0,0,0,0,1,9,32'hA0A0,     0,1,0,0,7,DB);
    vecs[10] = mk(0,1,1,32'h101,0,0,0,      0,1,1,0,7,DB);
    vecs[11] = mk(0,1,2,32'h102,0,0,0,      0,1,1,1,1,32'h101);
    vecs[12] = mk(0,1,3,32'h103,0,0,0,      0,1,1,1,2,32'h102);
    vecs[13] = mk(0,1,4,32'h104,0,0,0,      0,1,1,1,3,32'h103);
    vecs[14] = mk(0,1,5,32'h105,0,0,0,      1,1,1,1,4,32'h104);
    vecs[15] = mk(0,1,5,32'h105,0,0,0,      0,1,0,1,9,32'hA0A0);
    vecs[16] = mk(0,1,6,32'h106,0,0,0,      0,1,0,1,5,32'h105);
    vecs[17] = mk(0,0,0,0,0,0,0,            0,1,0,1,6,32'h106);
    vecs[18] = mk(0,0,0,0,0,0,0,            0,1,0,0,6,32'h106);
    vecs[19] = mk(0,1,10,32'h200,1,11,32'h300, 0,1,0,0,6,32'h106);
    vecs[20] = mk(0,1,12,32'h201,1,13,32'h301, 0,1,1,1,10,32'h200);
    vecs[21] = mk(0,1,14,32'h202,1,15,32'h302, 0,0,2,1,12,32'h201);
    vecs[22] = mk(0,1,16,32'h203,1,15,32'h302, 0,0,2,1,14,32'h202);
    vecs[23] = mk(0,1,17,32'h204,1,15,32'h302, 0,0,2,1,16,32'h203);
    vecs[24] = mk(0,1,18,32'h205,1,15,32'h302, 1,0,2,1,17,32'h204);
    vecs[25] = mk(0,1,18,32'h205,1,15,32'h302, 0,1,1,1,11,32'h300);
    vecs[26] = mk(1,1,19,32'h206,0,0,0,     0,0,2,1,18,32'h205);
    vecs[27] = mk(0,0,0,0,0,0,0,            0,1,0,0,0,0);
    vecs[28] = mk(0,0,0,0,0,0,0,            0,1,0,0,0,0);
    vecs[29] = mk(0,0,0,0,0,0,0,            0,1,0,0,0,0);

    drive(1,0,0,0,0,0,0);
    repeat (2) @(posedge clock);
    #1;

    for (int i = 0; i < 30; i++) begin
      drive(vecs[i].rst, vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].mv, vecs[i].mr, vecs[i].md);
      @(negedge clock);
      chk_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].rdy, vecs[i].cnt, vecs[i].we, vecs[i].wr, vecs[i].wd);
      @(posedge clock); #1;
    end

    // Simultaneous push and pop at occupancy 1 keeps count and order.
    drive(1,0,0,0,0,0,0);
    @(posedge clock); #1;
    drive(0,0,0,0,1,20,32'hAAAA0001);
    @(negedge clock); chk("seq.cnt0", 32'(md_count), 0);
    @(posedge clock); #1;
    drive(0,0,0,0,1,21,32'hAAAA0002);
    @(negedge clock); chk("seq.cnt1", 32'(md_count), 1);
    @(posedge clock); #1;
    drive(0,0,0,0,0,0,0);
    @(negedge clock);
    chk("seq.cnt_pushpop", 32'(md_count), 1);
    chk("seq.first_reg", 32'(ctrl_writeReg), 20);
    chk("seq.first_data", data_writeReg, 32'hAAAA0001);
    @(posedge clock); #1;
    @(negedge clock);
    chk("seq.cnt_drain", 32'(md_count), 0);
    chk("seq.second_reg", 32'(ctrl_writeReg), 21);
    chk("seq.second_data", data_writeReg, 32'hAAAA0002);
    @(posedge clock); #1;
    @(negedge clock);
    chk("seq.idle_we", 32'(ctrl_writeEnable), 0);
    @(posedge clock); #1;

    // Randomized traffic; a stalled ALU request is held as the protocol requires.
    drive(1,0,0,0,0,0,0);
    @(negedge clock); model_step();
    @(posedge clock); #1;
    begin
      logic held = 0;
      for (int i = 0; i < 3000; i++) begin
        ctrl_reset = ($urandom_range(0, 199) == 0);
        if (!held) begin
          alu_valid = ($urandom_range(0, 9) < 6);
          alu_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          alu_data  = $urandom;
        end
        md_valid = ($urandom_range(0, 1) == 1);
        md_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        md_data  = $urandom;
        @(negedge clock);
        chk_outs("rand", m_stall(), m_q.size() < 2, 2'(m_q.size()), m_we, m_wreg, m_wdata);
        held = m_stall() && !ctrl_reset;
        model_step();
        @(posedge clock); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
